// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scan controller with
// double-buffered BCD display value and leading-zero blanking.
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - new value offered on din
//   in_ready   - registered; high when the load buffer is empty
//   din        - four BCD digits, digit0 = din[3:0]
//   lz_blank   - leading-zero blanking enable
//   bcd_out    - BCD code of the digit currently scanned
//   dig_en_n   - active-low digit enables, at most one low
//   frame_done - one-cycle pulse after the digit3 slot ends
module seg_scan_ctrl #(
    parameter int DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] din,
    input  logic        lz_blank,
    output logic [3:0]  bcd_out,
    output logic [3:0]  dig_en_n,
    output logic        frame_done
);
    localparam int CW = $clog2(DIV);

    typedef enum logic {EMPTY, PENDING} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   disp;
    logic [15:0]   pend;
    logic          slot_end;
    logic          frame_end;
    logic          blank;

    assign slot_end  = cnt == CW'(DIV - 1);
    assign frame_end = slot_end && idx == 2'd3;

    // A digit is a leading zero when it and every more-significant nibble are zero;
    // digit0 always shows so that a value of zero still displays "0".
    assign blank    = lz_blank && idx != 2'd0 && (disp >> {idx, 2'b00}) == 16'h0;
    assign bcd_out  = disp[{idx, 2'b00} +: 4];
    // cnt==0 is a dead cycle with all digits off to avoid ghosting between digits.
    assign dig_en_n = (cnt == '0 || blank) ? 4'hF : ~(4'b0001 << idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= 2'd0;
            disp       <= 16'h0;
            pend       <= 16'h0;
            state      <= EMPTY;
            in_ready   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            idx        <= slot_end ? idx + 2'd1 : idx;
            frame_done <= frame_end;
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        pend     <= din;
                        state    <= PENDING;
                        in_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    // Commit only at the frame boundary so a frame never tears.
                    if (frame_end) begin
                        disp     <= pend;
                        state    <= EMPTY;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl (DIV=4) using a
// vector table, hand sequences and randomized traffic against a time-based model.
module tb_seg_scan_ctrl;
    localparam int DIV = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] din = 16'h0;
    logic        lz_blank = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_en_n;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;

    // Model: t counts rising edges since reset release; slot/digit follow from t.
    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pending;
    logic        m_fd;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        lz;
        logic [3:0]  dig;
        logic [3:0]  bcd;
        logic        fd;
        logic        rdy;
    } vec_t;

    vec_t tbl[20];

    seg_scan_ctrl #(.DIV(DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .din(din),
        .lz_blank(lz_blank),
        .bcd_out(bcd_out),
        .dig_en_n(dig_en_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d got %h expected %h", name, t, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_dig();
        int idx = (t / DIV) % 4;
        int nsig = 1;
        for (int k = 0; k < 4; k++)
            if (((m_disp >> (4 * k)) & 16'hF) != 0) nsig = k + 1;
        if (t % DIV == 0 || (lz_blank && idx >= nsig)) return 4'hF;
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic [3:0] exp_bcd();
        int idx = (t / DIV) % 4;
        return 4'((m_disp >> (4 * idx)) & 16'hF);
    endfunction

    task automatic model_reset();
        t = 0;
        m_disp = 16'h0;
        m_pend = 16'h0;
        m_pending = 1'b0;
        m_fd = 1'b0;
    endtask

    task automatic model_edge();
        logic boundary;
        boundary = (t % FRAME) == FRAME - 1;
        m_fd = boundary;
        if (m_pending) begin
            if (boundary) begin
                m_disp = m_pend;
                m_pending = 1'b0;
            end
        end else if (in_valid) begin
            m_pend = din;
            m_pending = 1'b1;
        end
        t++;
    endtask

    task automatic check_model();
        chk("dig_en_n", {12'h0, dig_en_n}, {12'h0, exp_dig()});
        chk("bcd_out", {12'h0, bcd_out}, {12'h0, exp_bcd()});
        chk("in_ready", {15'h0, in_ready}, {15'h0, ~m_pending});
        chk("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cycle(input logic v, input logic [15:0] d, input logic lz);
        in_valid = v;
        din = d;
        lz_blank = lz;
        #1 check_model();
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst dig_en_n", {12'h0, dig_en_n}, 16'h000F);
        chk("rst bcd_out", {12'h0, bcd_out}, 16'h0000);
        chk("rst in_ready", {15'h0, in_ready}, 16'h0001);
        chk("rst frame_done", {15'h0, frame_done}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 16'h0000, 1'b0, 4'hD, 4'h0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b0, 4'hD, 4'h0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 4'hD, 4'h0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 4'hB, 4'h0, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 4'hB, 4'h0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 4'hB, 4'h0, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 16'h1234, 1'b0, 4'hE, 4'h0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b0, 1'b0};

        model_reset();
        do_reset();

        // First frames after reset, with a load offered mid-frame.
        for (int i = 0; i < 20; i++) begin
            in_valid = tbl[i].v;
            din = tbl[i].d;
            lz_blank = tbl[i].lz;
            #1;
            chk("tbl dig_en_n", {12'h0, dig_en_n}, {12'h0, tbl[i].dig});
            chk("tbl bcd_out", {12'h0, bcd_out}, {12'h0, tbl[i].bcd});
            chk("tbl frame_done", {15'h0, frame_done}, {15'h0, tbl[i].fd});
            chk("tbl in_ready", {15'h0, in_ready}, {15'h0, tbl[i].rdy});
            tick();
        end

        // 1234 commits at the boundary, then shows 4,3,2,1.
        for (int i = 0; i < 32; i++) cycle(1'b0, 16'h0, 1'b0);

        // Leading-zero blanking cases.
        cycle(1'b1, 16'h0007, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b1, 16'h00A0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0, 1'b1);
        cycle(1'b1, 16'h0F00, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b0, 16'h0, 1'b1);

        // in_valid held high with changing din, including boundary-cycle captures.
        for (int i = 0; i < 120; i++) cycle(1'b1, 16'($urandom), 1'($urandom));

        // Reset while a value is pending: it must never reach the display.
        while (t % FRAME != 5) cycle(1'b0, 16'h0, 1'b0);
        cycle(1'b1, 16'h9999, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 48; i++) cycle(1'b0, 16'h0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] d;
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            cycle(1'($urandom_range(0, 7) == 0), d, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
